// File: rtl/fft_pkg.sv
// Shared definitions for the FFT chain: default frame geometry and bank-select type.
package fft_pkg;

  localparam int FFT_SAMPLES = 4;
  localparam int FFT_WIDTH   = 32;

  typedef logic bank_sel_t;

endpackage

// File: rtl/bit_reverse_index.sv
// Combinational mirror of an index: bit gi of the result is bit LOG2-1-gi of the input.
module bit_reverse_index #(
  parameter int LOG2 = 2
) (
  input  logic [LOG2-1:0] idx,
  output logic [LOG2-1:0] rev_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < LOG2; gi++) begin : g_mirror
      assign rev_idx[gi] = idx[LOG2-1-gi];
    end
  endgenerate

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel FFT front end: writes samples at bit-reversed positions into
// ping-pong banks and presents each complete frame to FFT stage 0.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int SAMPLES = FFT_SAMPLES,
  parameter int WIDTH   = FFT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [WIDTH-1:0]           frame_out [SAMPLES-1:0],
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [$clog2(SAMPLES)-1:0] fill_level
);

  localparam int LOG2 = $clog2(SAMPLES);

  logic [WIDTH-1:0] bank_reg [2][SAMPLES];
  bank_sel_t        wr_bank_reg, wr_bank_next;
  bank_sel_t        rd_bank_reg, rd_bank_next;
  logic [1:0]       full_reg, full_next;
  logic [LOG2-1:0]  n_reg, n_next;
  logic [LOG2-1:0]  rev_idx;
  logic             accept;
  logic             release_frame;
  logic             last_sample;

  bit_reverse_index #(
    .LOG2 (LOG2)
  ) u_bit_reverse_index (
    .idx     (n_reg),
    .rev_idx (rev_idx)
  );

  assign in_ready    = !full_reg[wr_bank_reg] && !flush;
  assign frame_valid = full_reg[rd_bank_reg];
  assign fill_level  = n_reg;

  // Completion and release never hit the same bank: accept needs the write bank
  // empty, release needs the read bank full.
  always_comb begin
    accept        = in_valid && in_ready;
    release_frame = frame_valid && frame_ready;
    last_sample   = (n_reg == LOG2'(SAMPLES - 1));
    full_next     = full_reg;
    wr_bank_next  = wr_bank_reg;
    rd_bank_next  = rd_bank_reg;
    n_next        = n_reg;

    if (release_frame) begin
      full_next[rd_bank_reg] = 1'b0;
      rd_bank_next           = ~rd_bank_reg;
    end

    if (flush) begin
      n_next = '0;
    end else if (accept) begin
      if (last_sample) begin
        full_next[wr_bank_reg] = 1'b1;
        wr_bank_next           = ~wr_bank_reg;
        n_next                 = '0;
      end else begin
        n_next = n_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      full_reg    <= '0;
      n_reg       <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SAMPLES; i++) begin
          bank_reg[b][i] <= '0;
        end
      end
    end else begin
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      full_reg    <= full_next;
      n_reg       <= n_next;
      if (accept) begin
        bank_reg[wr_bank_reg][rev_idx] <= in_sample;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SAMPLES; gi++) begin : g_frame_out
      assign frame_out[gi] = bank_reg[rd_bank_reg][gi];
    end
  endgenerate

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: directed scenarios on a 4-sample and an
// 8-sample instance, plus a randomized run against a frame-queue reference model.
module tb_fft_frame_loader;

  typedef logic [31:0] frame4_t [4];

  logic        clk;
  logic        reset;

  logic [31:0] in_sample4;
  logic        in_valid4, in_ready4, flush4, frame_valid4, frame_ready4;
  logic [31:0] frame_out4 [3:0];
  logic [1:0]  fill_level4;

  logic [31:0] in_sample8;
  logic        in_valid8, in_ready8, flush8, frame_valid8, frame_ready8;
  logic [31:0] frame_out8 [7:0];
  logic [2:0]  fill_level8;

  int n_checks;
  int n_fail;

  fft_frame_loader #(.SAMPLES(4), .WIDTH(32)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .in_sample   (in_sample4),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .flush       (flush4),
    .frame_out   (frame_out4),
    .frame_valid (frame_valid4),
    .frame_ready (frame_ready4),
    .fill_level  (fill_level4)
  );

  fft_frame_loader #(.SAMPLES(8), .WIDTH(32)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .in_sample   (in_sample8),
    .in_valid    (in_valid8),
    .in_ready    (in_ready8),
    .flush       (flush8),
    .frame_out   (frame_out8),
    .frame_valid (frame_valid8),
    .frame_ready (frame_ready8),
    .fill_level  (fill_level8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference bit reversal by repeated halving, independent of any bit slicing.
  function automatic int bitrev(input int v, input int bits);
    int r;
    int x;
    r = 0;
    x = v;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic drive4(input logic v, input logic [31:0] d, input logic fr, input logic fl);
    @(negedge clk);
    in_valid4    = v;
    in_sample4   = d;
    frame_ready4 = fr;
    flush4       = fl;
    #1;
  endtask

  task automatic drive8(input logic v, input logic [31:0] d, input logic fr, input logic fl);
    @(negedge clk);
    in_valid8    = v;
    in_sample8   = d;
    frame_ready8 = fr;
    flush8       = fl;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid4 = 1'b0; flush4 = 1'b0; frame_ready4 = 1'b0;
    in_valid8 = 1'b0; flush8 = 1'b0; frame_ready8 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready4: got %b expected 1", in_ready4); end
    n_checks++; if (frame_valid4 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid4: got %b expected 0", frame_valid4); end
    n_checks++; if (fill_level4 !== 2'd0) begin n_fail++; $display("FAIL reset_fill_level4: got %0d expected 0", fill_level4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== 32'd0) begin n_fail++; $display("FAIL reset_frame_out4[%0d]: got %h expected 0", i, frame_out4[i]); end
    end
    n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready8: got %b expected 1", in_ready8); end
    n_checks++; if (frame_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid8: got %b expected 0", frame_valid8); end
    $display("test_reset done");
  endtask

  task automatic test_basic_mapping();
    logic [31:0] exp_f [4];
    exp_f = '{32'd10, 32'd30, 32'd20, 32'd40};
    drive4(1'b1, 32'd10, 1'b1, 1'b0);
    drive4(1'b1, 32'd20, 1'b1, 1'b0);
    drive4(1'b1, 32'd30, 1'b1, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", frame_valid4); end
    drive4(1'b1, 32'd40, 1'b1, 1'b0);
    n_checks++; if (fill_level4 !== 2'd3) begin n_fail++; $display("FAIL basic_fill_level: got %0d expected 3", fill_level4); end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b1) begin n_fail++; $display("FAIL basic_frame_valid: got %b expected 1", frame_valid4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== exp_f[i]) begin n_fail++; $display("FAIL basic_frame_out[%0d]: got %0d expected %0d", i, frame_out4[i], exp_f[i]); end
    end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b0) begin n_fail++; $display("FAIL basic_released: got %b expected 0", frame_valid4); end
    $display("test_basic_mapping done");
  endtask

  task automatic test_streaming();
    int          frames_seen;
    logic        exp_v;
    logic [31:0] e;
    frames_seen = 0;
    for (int k = 0; k <= 32; k++) begin
      drive8(k < 32, 32'(k), 1'b1, 1'b0);
      if (k < 32) begin
        n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready k=%0d: got %b expected 1", k, in_ready8); end
      end
      exp_v = (k >= 8) && (k % 8 == 0);
      n_checks++; if (frame_valid8 !== exp_v) begin n_fail++; $display("FAIL stream_frame_valid k=%0d: got %b expected %b", k, frame_valid8, exp_v); end
      if (frame_valid8 === 1'b1) begin
        for (int j = 0; j < 8; j++) begin
          e = 32'(bitrev(j, 3) + 8 * frames_seen);
          n_checks++; if (frame_out8[j] !== e) begin n_fail++; $display("FAIL stream_frame%0d_out[%0d]: got %0d expected %0d", frames_seen, j, frame_out8[j], e); end
        end
        frames_seen++;
      end
    end
    n_checks++; if (frames_seen != 4) begin n_fail++; $display("FAIL stream_frame_count: got %0d expected 4", frames_seen); end
    drive8(1'b0, 32'd0, 1'b0, 1'b0);
    $display("test_streaming done, %0d frames", frames_seen);
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_a = '{32'd10, 32'd30, 32'd20, 32'd40};
    exp_b = '{32'd50, 32'd70, 32'd60, 32'd80};
    for (int k = 0; k < 8; k++) begin
      drive4(1'b1, 32'(10 * (k + 1)), 1'b0, 1'b0);
      n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready k=%0d: got %b expected 1", k, in_ready4); end
    end
    for (int c = 0; c < 3; c++) begin
      drive4(1'b1, 32'd90, 1'b0, 1'b0);
      n_checks++; if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_stalled_ready c=%0d: got %b expected 0", c, in_ready4); end
      n_checks++; if (fill_level4 !== 2'd0) begin n_fail++; $display("FAIL bp_fill_level c=%0d: got %0d expected 0", c, fill_level4); end
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (frame_out4[i] !== exp_a[i]) begin n_fail++; $display("FAIL bp_hold_out[%0d] c=%0d: got %0d expected %0d", i, c, frame_out4[i], exp_a[i]); end
      end
    end
    drive4(1'b1, 32'd90, 1'b1, 1'b0);
    n_checks++; if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at_release: got %b expected 0", in_ready4); end
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_release: got %b expected 1", in_ready4); end
    n_checks++; if (frame_valid4 !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b expected 1", frame_valid4); end
    n_checks++; if (fill_level4 !== 2'd0) begin n_fail++; $display("FAIL bp_sample9_taken: got fill %0d expected 0", fill_level4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== exp_b[i]) begin n_fail++; $display("FAIL bp_second_out[%0d]: got %0d expected %0d", i, frame_out4[i], exp_b[i]); end
    end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", frame_valid4); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    logic [31:0] exp_f [4];
    exp_f = '{32'd1, 32'd3, 32'd2, 32'd4};
    drive4(1'b1, 32'd10, 1'b1, 1'b0);
    drive4(1'b1, 32'd20, 1'b1, 1'b0);
    drive4(1'b1, 32'd99, 1'b1, 1'b1);
    n_checks++; if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready4); end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++; if (fill_level4 !== 2'd0) begin n_fail++; $display("FAIL flush_fill_level: got %0d expected 0", fill_level4); end
    for (int k = 1; k <= 4; k++) drive4(1'b1, 32'(k), 1'b0, 1'b0);
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b1) begin n_fail++; $display("FAIL flush_frame_valid: got %b expected 1", frame_valid4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== exp_f[i]) begin n_fail++; $display("FAIL flush_frame_out[%0d]: got %0d expected %0d", i, frame_out4[i], exp_f[i]); end
    end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_f [4];
    exp_f = '{32'd5, 32'd7, 32'd6, 32'd8};
    for (int k = 0; k < 6; k++) drive4(1'b1, 32'(100 + k), 1'b0, 1'b0);
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (fill_level4 !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre_fill: got %0d expected 2", fill_level4); end
    apply_reset();
    n_checks++; if (frame_valid4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_valid: got %b expected 0", frame_valid4); end
    n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready4); end
    n_checks++; if (fill_level4 !== 2'd0) begin n_fail++; $display("FAIL rstmid_fill_level: got %0d expected 0", fill_level4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== 32'd0) begin n_fail++; $display("FAIL rstmid_frame_out[%0d]: got %h expected 0", i, frame_out4[i]); end
    end
    for (int k = 5; k <= 8; k++) drive4(1'b1, 32'(k), 1'b0, 1'b0);
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== exp_f[i]) begin n_fail++; $display("FAIL rstmid_clean_out[%0d]: got %0d expected %0d", i, frame_out4[i], exp_f[i]); end
    end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    $display("test_reset_mid done");
  endtask

  task automatic test_collision();
    logic [31:0] exp_b [4];
    exp_b = '{32'd21, 32'd23, 32'd22, 32'd24};
    for (int k = 11; k <= 14; k++) drive4(1'b1, 32'(k), 1'b0, 1'b0);
    for (int k = 21; k <= 23; k++) drive4(1'b1, 32'(k), 1'b0, 1'b0);
    drive4(1'b1, 32'd24, 1'b1, 1'b0);
    n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL coll_last_ready: got %b expected 1", in_ready4); end
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b1) begin n_fail++; $display("FAIL coll_frame_valid: got %b expected 1", frame_valid4); end
    n_checks++; if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL coll_one_full: got in_ready %b expected 1", in_ready4); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (frame_out4[i] !== exp_b[i]) begin n_fail++; $display("FAIL coll_frame_out[%0d]: got %0d expected %0d", i, frame_out4[i], exp_b[i]); end
    end
    drive4(1'b0, 32'd0, 1'b1, 1'b0);
    drive4(1'b0, 32'd0, 1'b0, 1'b0);
    n_checks++; if (frame_valid4 !== 1'b0) begin n_fail++; $display("FAIL coll_drained: got %b expected 0", frame_valid4); end
    $display("test_collision done");
  endtask

  // Model: a FIFO of completed frames (at most two) and the list of samples
  // gathered so far for the frame under collection.
  task automatic test_random();
    frame4_t     pend_q[$];
    logic [31:0] part_q[$];
    frame4_t     f;
    logic        v, fr, fl, exp_ready;
    logic [31:0] d;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom_range(0, 9) < 7);
      fr = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 19) == 0);
      d  = $urandom;
      drive4(v, d, fr, fl);
      exp_ready = (pend_q.size() < 2) && !fl;
      n_checks++; if (in_ready4 !== exp_ready) begin n_fail++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, in_ready4, exp_ready); end
      n_checks++; if (frame_valid4 !== (pend_q.size() > 0)) begin n_fail++; $display("FAIL rnd_frame_valid c=%0d: got %b expected %b", c, frame_valid4, pend_q.size() > 0); end
      n_checks++; if (fill_level4 !== 2'(part_q.size())) begin n_fail++; $display("FAIL rnd_fill_level c=%0d: got %0d expected %0d", c, fill_level4, part_q.size()); end
      if (pend_q.size() > 0) begin
        for (int i = 0; i < 4; i++) begin
          n_checks++; if (frame_out4[i] !== pend_q[0][i]) begin n_fail++; $display("FAIL rnd_frame_out[%0d] c=%0d: got %h expected %h", i, c, frame_out4[i], pend_q[0][i]); end
        end
      end
      if (pend_q.size() > 0 && fr) void'(pend_q.pop_front());
      if (fl) begin
        part_q.delete();
      end else if (v && exp_ready) begin
        part_q.push_back(d);
        if (part_q.size() == 4) begin
          for (int k = 0; k < 4; k++) f[bitrev(k, 2)] = part_q[k];
          pend_q.push_back(f);
          part_q.delete();
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    in_sample4 = '0; in_valid4 = 1'b0; flush4 = 1'b0; frame_ready4 = 1'b0;
    in_sample8 = '0; in_valid8 = 1'b0; flush8 = 1'b0; frame_ready8 = 1'b0;
    test_reset();
    test_basic_mapping();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_collision();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
